scratchpad_arbiter: RTL and testbench

//   Shares one single-port scratchpad between NUMREQ requesters with round-robin arbitration and optional burst lock.

---
 rtl/scratchpad_arbiter_pkg.sv | 17 +
 rtl/scratchpad_arbiter_rr_arbiter.sv | 27 ++
 rtl/scratchpad_arbiter.sv | 138 +++++++++++++
 tb/tb_scratchpad_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scratchpad_arbiter_pkg.sv
// Shared definitions for the scratchpad arbiter: power-sequencing FSM encodings
// and the scratchpad geometry helpers.
package scratchpad_arbiter_pkg;

   localparam logic [1:0] ST_SLEEP  = 2'd0;
   localparam logic [1:0] ST_WAKE   = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;

   function automatic int sp_addr_width(input int size);
      return (size > 2) ? $clog2(size) : 1;
   endfunction

   function automatic int sp_data_width(input int lanes, input int lane_bits);
      return lanes * lane_bits;
   endfunction

endpackage

// File: rtl/scratchpad_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping around; one-hot result.
module rr_arbiter #(
   parameter  int NUMREQ = 4,
   localparam int PTRW   = $clog2(NUMREQ)
) (
   input  logic [NUMREQ-1:0] i_req,
   input  logic [PTRW-1:0]   i_ptr,
   output logic [NUMREQ-1:0] o_grant
);

   // NOTE: every output of an always_comb gets a default first, so no path
   // through the block can leave it unassigned and infer a latch.
   always_comb begin
      o_grant = '0;
      // Walk from the farthest offset down so the nearest requester wins last.
      for (int off = NUMREQ - 1; off >= 0; off--) begin
         int idx;
         idx = (int'(i_ptr) + off) % NUMREQ;
         if (i_req[idx]) begin
            o_grant      = '0;
            o_grant[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/scratchpad_arbiter.sv
// Round-robin / burst-lock arbiter in front of a single-port scratchpad, with
// idle-timeout power gating of the scratchpad enable and in-order read returns.
module scratchpad_arbiter
   import scratchpad_arbiter_pkg::*;
#(
   parameter  int NUMREQ       = 4,
   parameter  int NUMHELPER    = 4,
   parameter  int BITWIDTH     = 25,
   parameter  int SIZE         = 32,
   parameter  int READ_LATENCY = 1,
   parameter  int IDLE_TIMEOUT = 8,
   localparam int ADDRW        = sp_addr_width(SIZE),
   localparam int DATAW        = sp_data_width(NUMHELPER, BITWIDTH)
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [NUMREQ-1:0]       req_valid,
   input  logic [NUMREQ-1:0]       req_we,
   input  logic [NUMREQ-1:0]       req_lock,
   input  logic [NUMREQ*ADDRW-1:0] req_addr,
   input  logic [NUMREQ*DATAW-1:0] req_wdata,
   output logic [NUMREQ-1:0]       req_ready,
   output logic [NUMREQ-1:0]       resp_valid,
   output logic [DATAW-1:0]        resp_data,
   output logic                    sp_on,
   output logic                    sp_write_enable,
   output logic [ADDRW-1:0]        sp_address,
   output logic [DATAW-1:0]        sp_data_in,
   input  logic [DATAW-1:0]        sp_data_out
);

   localparam int PTRW = $clog2(NUMREQ);
   localparam int CNTW = $clog2(IDLE_TIMEOUT + 1);

   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic [PTRW-1:0]   r_ptr;
   logic [CNTW-1:0]   r_idle_cnt;
   logic              r_lock_valid;
   logic [PTRW-1:0]   r_lock_idx;
   logic [NUMREQ-1:0] r_pipe [READ_LATENCY];

   logic              w_any_valid;
   logic              w_active;
   logic              w_lock_hold;
   logic              w_xfer;
   logic              w_pipe_empty;
   logic              w_timeout;
   logic [NUMREQ-1:0] w_rr_req;
   logic [NUMREQ-1:0] w_rr_grant;
   logic [NUMREQ-1:0] w_grant;
   logic [PTRW-1:0]   w_gidx;

   assign w_any_valid = |req_valid;
   // Outputs are forced quiet while reset is held, so a response already in
   // the pipe cannot escape during the reset cycle itself.
   assign w_active    = reset_n && (r_state == ST_ACTIVE);
   assign w_lock_hold = w_active && r_lock_valid
                        && req_valid[r_lock_idx] && req_lock[r_lock_idx];
   assign w_rr_req    = req_valid & {NUMREQ{w_active}};
   assign w_timeout   = (r_idle_cnt == CNTW'(IDLE_TIMEOUT));

   rr_arbiter #(.NUMREQ(NUMREQ)) u_rr (
      .i_req   (w_rr_req),
      .i_ptr   (r_ptr),
      .o_grant (w_rr_grant)
   );

   assign w_grant = w_lock_hold ? ({{(NUMREQ-1){1'b0}}, 1'b1} << r_lock_idx) : w_rr_grant;
   assign w_xfer  = |w_grant;

   always_comb begin
      w_gidx = '0;
      for (int i = 0; i < NUMREQ; i++) begin
         if (w_grant[i]) w_gidx = PTRW'(i);
      end
   end

   always_comb begin
      w_pipe_empty = 1'b1;
      for (int k = 0; k < READ_LATENCY; k++) begin
         if (|r_pipe[k]) w_pipe_empty = 1'b0;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_SLEEP:  if (w_any_valid) w_state_next = ST_WAKE;
         ST_WAKE:   w_state_next = ST_ACTIVE;
         ST_ACTIVE: if (!w_any_valid && w_timeout && w_pipe_empty) w_state_next = ST_SLEEP;
         default:   w_state_next = ST_SLEEP;
      endcase
   end

   assign req_ready       = w_grant;
   assign sp_on           = reset_n && (r_state != ST_SLEEP);
   assign sp_write_enable = w_xfer && req_we[w_gidx];
   assign sp_address      = w_xfer ? req_addr[int'(w_gidx)*ADDRW +: ADDRW] : '0;
   assign sp_data_in      = w_xfer ? req_wdata[int'(w_gidx)*DATAW +: DATAW] : '0;
   assign resp_valid      = reset_n ? r_pipe[READ_LATENCY-1] : '0;
   assign resp_data       = (|resp_valid) ? sp_data_out : '0;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state      <= ST_SLEEP;
         r_ptr        <= '0;
         r_idle_cnt   <= '0;
         r_lock_valid <= 1'b0;
         r_lock_idx   <= '0;
         // NOTE: the tag pipe is small and control-bearing, so it is cleared
         // on reset; a stale tag would otherwise surface as a phantom response.
         for (int k = 0; k < READ_LATENCY; k++) r_pipe[k] <= '0;
      end else begin
         // NOTE: all sequential state is updated with non-blocking assignments
         // so every register samples pre-edge values regardless of order.
         r_state <= w_state_next;

         if (r_state != ST_ACTIVE || w_any_valid) begin
            r_idle_cnt <= '0;
         end else if (!w_timeout) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
         end

         if (w_xfer && !w_lock_hold) begin
            r_ptr <= (int'(w_gidx) == NUMREQ - 1) ? '0 : w_gidx + 1'b1;
         end

         // A lock owner that keeps valid & lock is re-granted, so this also holds it.
         r_lock_valid <= w_xfer && req_lock[w_gidx];
         r_lock_idx   <= w_gidx;

         r_pipe[0] <= (w_xfer && !req_we[w_gidx]) ? w_grant : '0;
         for (int k = 1; k < READ_LATENCY; k++) r_pipe[k] <= r_pipe[k-1];
      end
   end

endmodule

// File: tb/tb_scratchpad_arbiter.sv
// Directed bench for scratchpad_arbiter with a one-cycle-latency scratchpad model.
module tb_scratchpad_arbiter;

   localparam int NUMREQ = 4;
   localparam int ADDRW  = 5;
   localparam int DATAW  = 100;

   logic                    clock = 1'b0;
   logic                    reset_n;
   logic [NUMREQ-1:0]       req_valid;
   logic [NUMREQ-1:0]       req_we;
   logic [NUMREQ-1:0]       req_lock;
   logic [NUMREQ*ADDRW-1:0] req_addr;
   logic [NUMREQ*DATAW-1:0] req_wdata;
   logic [NUMREQ-1:0]       req_ready;
   logic [NUMREQ-1:0]       resp_valid;
   logic [DATAW-1:0]        resp_data;
   logic                    sp_on;
   logic                    sp_write_enable;
   logic [ADDRW-1:0]        sp_address;
   logic [DATAW-1:0]        sp_data_in;
   logic [DATAW-1:0]        sp_data_out;

   logic [DATAW-1:0] mem [32];
   logic             mem_loaded = 1'b0;
   logic [DATAW-1:0] exp_mem [32];

   int n_checks = 0;
   int n_errors = 0;

   scratchpad_arbiter dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .req_valid       (req_valid),
      .req_we          (req_we),
      .req_lock        (req_lock),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .req_ready       (req_ready),
      .resp_valid      (resp_valid),
      .resp_data       (resp_data),
      .sp_on           (sp_on),
      .sp_write_enable (sp_write_enable),
      .sp_address      (sp_address),
      .sp_data_in      (sp_data_in),
      .sp_data_out     (sp_data_out)
   );

   always #5 clock = ~clock;

   function automatic logic [DATAW-1:0] word(input int i);
      return DATAW'(i) * DATAW'(100'h1_2345) + DATAW'(7);
   endfunction

   // Scratchpad model: registered read, one cycle of latency.
   always @(posedge clock) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 32; i++) mem[i] <= word(i);
         mem_loaded  <= 1'b1;
         sp_data_out <= '0;
      end else if (sp_on) begin
         if (sp_write_enable) mem[sp_address] <= sp_data_in;
         else                 sp_data_out     <= mem[sp_address];
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_all();
      req_valid = '0;
      req_we    = '0;
      req_lock  = '0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   task automatic drive(input int i, input logic v, input logic we, input logic lk,
                        input int addr, input logic [DATAW-1:0] wd);
      req_valid[i]               = v;
      req_we[i]                  = we;
      req_lock[i]                = lk;
      req_addr[i*ADDRW +: ADDRW] = ADDRW'(addr);
      req_wdata[i*DATAW +: DATAW] = wd;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) exp_mem[i] = word(i);
      reset_n = 1'b0;
      clear_all();
      drive(0, 1'b1, 1'b0, 1'b0, 0, '0);
      step();
      step();
      #2;
      check("rst_sp_on", sp_on, 0);
      check("rst_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_sp_we", sp_write_enable, 0);
      check("rst_sp_addr", sp_address, 0);
      step();

      // Wake-up then first write
      reset_n = 1'b1;
      clear_all();
      drive(0, 1'b1, 1'b1, 1'b0, 3, DATAW'(5));
      #2;
      check("t1_sleep_sp_on", sp_on, 0);
      check("t1_sleep_ready", req_ready, 0);
      step(); #2;
      check("t1_wake_sp_on", sp_on, 1);
      check("t1_wake_ready", req_ready, 0);
      step(); #2;
      check("t1_grant", req_ready, 4'b0001);
      check("t1_we", sp_write_enable, 1);
      check("t1_addr", sp_address, 3);
      check("t1_din", sp_data_in, 5);
      exp_mem[3] = DATAW'(5);
      step();

      // Write by port 1 then read-back by port 3
      clear_all();
      drive(1, 1'b1, 1'b1, 1'b0, 7, DATAW'(12'hABC));
      #2;
      check("t6_wr_grant", req_ready, 4'b0010);
      check("t6_wr_we", sp_write_enable, 1);
      check("t6_wr_addr", sp_address, 7);
      check("t6_wr_din", sp_data_in, 12'hABC);
      exp_mem[7] = DATAW'(12'hABC);
      step();
      clear_all();
      drive(3, 1'b1, 1'b0, 1'b0, 7, '0);
      #2;
      check("t6_rd_grant", req_ready, 4'b1000);
      check("t6_rd_we", sp_write_enable, 0);
      check("t6_rd_addr", sp_address, 7);
      check("t6_no_resp_yet", resp_valid, 0);
      step();
      clear_all();
      #2;
      check("t6_resp_valid", resp_valid, 4'b1000);
      check("t6_resp_data", resp_data, exp_mem[7]);
      step();

      // All four reading continuously: rotation 0,1,2,3,0
      for (int i = 0; i < NUMREQ; i++) drive(i, 1'b1, 1'b0, 1'b0, i, '0);
      for (int k = 0; k < 5; k++) begin
         #2;
         check($sformatf("t2_grant%0d", k), req_ready, 4'b0001 << (k % 4));
         if (k > 0) begin
            check($sformatf("t2_resp_valid%0d", k), resp_valid, 4'b0001 << ((k - 1) % 4));
            check($sformatf("t2_resp_data%0d", k), resp_data, exp_mem[(k - 1) % 4]);
         end
         step();
      end
      clear_all();
      #2;
      check("t2_last_resp_valid", resp_valid, 4'b0001);
      check("t2_last_resp_data", resp_data, exp_mem[0]);
      step();

      // Burst lock by requester 2 while the others wait
      clear_all();
      drive(2, 1'b1, 1'b0, 1'b1, 2, '0);
      #2;
      check("t3_lock_first", req_ready, 4'b0100);
      step();
      drive(0, 1'b1, 1'b0, 1'b0, 0, '0);
      drive(1, 1'b1, 1'b0, 1'b0, 1, '0);
      drive(3, 1'b1, 1'b0, 1'b0, 3, '0);
      for (int k = 1; k < 5; k++) begin
         #2;
         check($sformatf("t3_lock_hold%0d", k), req_ready, 4'b0100);
         check($sformatf("t3_lock_resp%0d", k), resp_valid, 4'b0100);
         step();
      end
      drive(2, 1'b0, 1'b0, 1'b0, 0, '0);
      #2;
      check("t3_after_lock", req_ready, 4'b1000);
      check("t3_last_lock_resp", resp_valid, 4'b0100);
      step();
      clear_all();
      #2;
      check("t3_resp3_valid", resp_valid, 4'b1000);
      check("t3_resp3_data", resp_data, exp_mem[3]);

      // Idle timeout: enable stays up through nine idle cycles, then drops
      for (int k = 0; k < 9; k++) begin
         check($sformatf("t4_idle_on%0d", k), sp_on, 1);
         step(); #2;
      end
      check("t4_sleep_sp_on", sp_on, 0);
      drive(0, 1'b1, 1'b0, 1'b0, 1, '0);
      #2;
      check("t4_sleep_ready", req_ready, 0);
      step(); #2;
      check("t4_wake_sp_on", sp_on, 1);
      check("t4_wake_ready", req_ready, 0);
      step(); #2;
      check("t4_regrant", req_ready, 4'b0001);
      check("t4_regrant_addr", sp_address, 1);
      step();
      clear_all();
      #2;
      check("t4_resp_valid", resp_valid, 4'b0001);
      check("t4_resp_data", resp_data, exp_mem[1]);

      // Request arriving exactly when the idle count hits the timeout
      repeat (8) step();
      drive(1, 1'b1, 1'b0, 1'b0, 2, '0);
      #2;
      check("tb_edge_sp_on", sp_on, 1);
      check("tb_edge_grant", req_ready, 4'b0010);
      step();
      clear_all();
      drive(0, 1'b1, 1'b0, 1'b0, 0, '0);
      #2;
      check("tb_edge_stay_on", sp_on, 1);
      check("tb_edge_resp_valid", resp_valid, 4'b0010);
      check("tb_edge_resp_data", resp_data, exp_mem[2]);
      check("tb_edge_next_grant", req_ready, 4'b0001);
      step();

      // Reset right after a read transfer
      reset_n = 1'b0;
      #2;
      check("t5_rst_resp_valid", resp_valid, 0);
      check("t5_rst_resp_data", resp_data, 0);
      check("t5_rst_sp_on", sp_on, 0);
      check("t5_rst_ready", req_ready, 0);
      check("t5_rst_we", sp_write_enable, 0);
      step(); #2;
      check("t5_rst2_resp_valid", resp_valid, 0);
      check("t5_rst2_sp_on", sp_on, 0);
      check("t5_rst2_ready", req_ready, 0);
      check("t5_rst2_addr", sp_address, 0);
      reset_n = 1'b1;
      clear_all();
      step(); #2;
      check("t5_post_resp_valid", resp_valid, 0);
      check("t5_post_sp_on", sp_on, 0);
      step(); #2;
      check("t5_post2_resp_valid", resp_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
